// File: rtl/lsu_bus_if.sv
// Word-wide request/grant/response data bus between the load/store unit (master) and memory (slave).
interface lsu_bus_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned BE_W = XLEN / 8;

    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [BE_W-1:0] bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: sized accesses to word bus transactions, load extension, stall control.
// Optional bus timeout watchdog enabled by defining LSU_BUS_TIMEOUT_EN.
module load_store_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_we,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_data,
    output logic             access_done,
    output logic             stall_memory,
    output logic             misaligned,
    output logic             bus_err,
    lsu_bus_if.master        bus
);

    if (XLEN != 32 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("load_store_unit supports XLEN=32 and TIMEOUT_CYCLES>0 only");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic            illegal_c;
    logic            misalign_c;
    logic            access_bad_c;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_rep_c;
    logic [XLEN-1:0] rdata_sh_c;
    logic [XLEN-1:0] load_ext_c;
    logic            req_c;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             timeout_c;

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Access decode: legality, lane enables, store replication and load extraction.
    always_comb begin
        illegal_c = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal_c = 1'b0;
            3'b100, 3'b101:         illegal_c = mem_we;
            default:                illegal_c = 1'b1;
        endcase

        misalign_c = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign_c = addr[0];
            2'b10:   misalign_c = (addr[1:0] != 2'b00);
            default: misalign_c = 1'b0;
        endcase
        access_bad_c = illegal_c | misalign_c;

        be_c        = 4'b1111;
        wdata_rep_c = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_c        = 4'b0001 << addr[1:0];
                wdata_rep_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c        = 4'b0011 << addr[1:0];
                wdata_rep_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c        = 4'b1111;
                wdata_rep_c = wdata;
            end
        endcase

        rdata_sh_c = bus.bus_rdata >> {addr[1:0], 3'b000};
        case (funct3)
            3'b000:  load_ext_c = {{(XLEN-8){rdata_sh_c[7]}},   rdata_sh_c[7:0]};
            3'b001:  load_ext_c = {{(XLEN-16){rdata_sh_c[15]}}, rdata_sh_c[15:0]};
            3'b100:  load_ext_c = {{(XLEN-8){1'b0}},            rdata_sh_c[7:0]};
            3'b101:  load_ext_c = {{(XLEN-16){1'b0}},           rdata_sh_c[15:0]};
            default: load_ext_c = rdata_sh_c;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            load_data_q <= '0;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    // Next-state and load result.
    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
`ifdef LSU_BUS_TIMEOUT_EN
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (access_bad_c) begin
                        state_d     = S_DONE;
                        load_data_d = '0;
                    end else if (bus.bus_gnt) begin
                        state_d = mem_we ? S_DONE : S_WAIT_R;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.bus_gnt) begin
                    state_d = mem_we ? S_DONE : S_WAIT_R;
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (timeout_c) begin
                    state_d     = S_DONE;
                    load_data_d = '0;
                    bus_err_d   = 1'b1;
                end
`endif
            end
            S_WAIT_R: begin
                if (bus.bus_rvalid) begin
                    state_d     = S_DONE;
                    load_data_d = load_ext_c;
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (timeout_c) begin
                    state_d     = S_DONE;
                    load_data_d = '0;
                    bus_err_d   = 1'b1;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef LSU_BUS_TIMEOUT_EN
        // Watchdog restarts on every entry into a waiting state.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_REQ || state_q == S_WAIT_R) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    // Outputs: bus fields are only driven while a request is presented.
    always_comb begin
        req_c        = 1'b0;
        stall_memory = 1'b0;
        misaligned   = 1'b0;
        access_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    stall_memory = 1'b1;
                    misaligned   = access_bad_c;
                    req_c        = ~access_bad_c;
                end
            end
            S_REQ: begin
                stall_memory = 1'b1;
                req_c        = 1'b1;
            end
            S_WAIT_R: stall_memory = 1'b1;
            S_DONE:   access_done  = 1'b1;
            default:  stall_memory = 1'b0;
        endcase

        bus.bus_req   = req_c;
        bus.bus_we    = req_c & mem_we;
        bus.bus_addr  = req_c ? {addr[XLEN-1:2], 2'b00} : '0;
        bus.bus_be    = req_c ? be_c : 4'b0000;
        bus.bus_wdata = req_c ? wdata_rep_c : '0;
    end

    assign load_data = load_data_q;

`ifdef LSU_BUS_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule
